// File: rtl/ram_based_fifo_return_packer_pkg.sv
// rtl/ram_based_fifo_return_packer_pkg.sv - shared parameters for the return-path packing FIFO
package ram_based_fifo_return_packer_pkg;

    localparam string DEVICE      = "simulation";
    localparam int    DEF_DATA_W  = 8;
    localparam int    DEF_RATIO   = 16;
    localparam int    DEF_DATA_R  = DEF_DATA_W * DEF_RATIO;
    localparam int    DEF_DEPTH_R = 8;
    localparam int    LANE_W      = $clog2(DEF_RATIO);

endpackage

// File: rtl/return_pack_reg.sv
// rtl/return_pack_reg.sv - narrow-to-wide lane packer with flush/pad and commit strobe
module return_pack_reg
    import ram_based_fifo_return_packer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RATIO  = DEF_RATIO,
    parameter int DATA_R = DATA_W * RATIO,
    parameter int LW     = $clog2(RATIO)
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_flush,
    input  logic              i_ram_full,
    output logic              o_full,
    output logic              o_commit,
    output logic [DATA_R-1:0] o_word,
    output logic [LW:0]       o_pad_num
);

    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
    localparam logic [LW:0]   RATIO_L   = (LW + 1)'(RATIO);

    logic [LW-1:0]     lane_cnt;
    logic [DATA_R-1:0] pack_reg;
    logic [DATA_R-1:0] merged;
    logic [LW:0]       eff_lanes;
    logic              last_lane;
    logic              wacc;
    logic              fire_flush;
    logic              flush_commit;

    // Only the word-completing byte is refused while the RAM is full;
    // earlier lanes can keep filling the pack register.
    assign last_lane    = (lane_cnt == LAST_LANE);
    assign o_full       = i_ram_full & last_lane;
    assign wacc         = i_wren & ~o_full;
    assign eff_lanes    = {1'b0, lane_cnt} + {{LW{1'b0}}, wacc};
    assign fire_flush   = i_flush & ~(i_ram_full & (eff_lanes != '0));
    assign flush_commit = fire_flush & (eff_lanes != '0);
    assign o_commit     = (wacc & last_lane) | flush_commit;
    assign o_word       = merged;

    // Word as it would look with this cycle's byte folded in; unused lanes stay zero.
    always_comb begin
        merged = pack_reg;
        if (wacc) begin
            merged[lane_cnt*DATA_W +: DATA_W] = i_wrdata;
        end
    end

    // Lane counter, pack register and pad count of the most recent flush commit.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt  <= '0;
            pack_reg  <= '0;
            o_pad_num <= '0;
        end else begin
            if (o_commit) begin
                lane_cnt <= '0;
                pack_reg <= '0;
            end else if (wacc) begin
                lane_cnt <= lane_cnt + 1'b1;
                pack_reg <= merged;
            end
            if (flush_commit) begin
                o_pad_num <= RATIO_L - eff_lanes;
            end
        end
    end

endmodule

// File: rtl/ram_based_fifo_return_packer.sv
// rtl/ram_based_fifo_return_packer.sv - packing FIFO top: RAM, pointers, counts, read register
module ram_based_fifo_return_packer
    import ram_based_fifo_return_packer_pkg::*;
#(
    parameter int DATA_W                 = DEF_DATA_W,
    parameter int DATA_R                 = DEF_DATA_R,
    parameter int RATIO                  = DEF_RATIO,
    parameter int DEPTH_R                = DEF_DEPTH_R,
    parameter int ALMOST_FULL_THRESHOLD  = 2**(DEPTH_R-1) - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
    input  logic                       system_clk,
    input  logic                       rst_n,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_almost_full,
    input  logic                       i_rden,
    output logic [DATA_R-1:0]          o_rddata,
    output logic                       o_empty,
    output logic                       o_almost_empty,
    output logic [DEPTH_R:0]           o_word_cnt,
    output logic [$clog2(RATIO):0]     o_pad_num
);

    localparam int LW    = $clog2(RATIO);
    localparam int WORDS = 2**DEPTH_R;

    logic [DEPTH_R-1:0] wrptr;
    logic [DEPTH_R-1:0] rdptr;
    logic [DEPTH_R:0]   word_cnt;
    logic               ram_full;
    logic               racc;
    logic               commit;
    logic [DATA_R-1:0]  commit_word;
    logic [DATA_R-1:0]  ram_rdata;

    assign ram_full       = (word_cnt == (DEPTH_R + 1)'(WORDS));
    assign o_empty        = (word_cnt == '0);
    assign racc           = i_rden & ~o_empty;
    assign o_word_cnt     = word_cnt;
    assign o_almost_full  = (word_cnt >= (DEPTH_R + 1)'(ALMOST_FULL_THRESHOLD));
    assign o_almost_empty = (word_cnt <  (DEPTH_R + 1)'(ALMOST_EMPTY_THRESHOLD));

    return_pack_reg #(
        .DATA_W (DATA_W),
        .RATIO  (RATIO),
        .DATA_R (DATA_R),
        .LW     (LW)
    ) u_pack (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .i_wren     (i_wren),
        .i_wrdata   (i_wrdata),
        .i_flush    (i_flush),
        .i_ram_full (ram_full),
        .o_full     (o_full),
        .o_commit   (commit),
        .o_word     (commit_word),
        .o_pad_num  (o_pad_num)
    );

    generate
        if (DEVICE == "simulation") begin : g_sim_ram
            logic [DATA_R-1:0] mem [WORDS];
            // Behavioural storage; contents are don't-care after reset since pointers restart.
            always_ff @(posedge system_clk) begin
                if (commit) begin
                    mem[wrptr] <= commit_word;
                end
            end
            assign ram_rdata = mem[rdptr];
        end else begin : g_return_ram
            logic [DATA_R-1:0] ram [WORDS];
            // Equal write/read width simple dual-port pattern for the vendor RAM flow.
            always_ff @(posedge system_clk) begin
                if (commit) begin
                    ram[wrptr] <= commit_word;
                end
            end
            assign ram_rdata = ram[rdptr];
        end
    endgenerate

    // Pointers, committed-word count and the registered read port.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr    <= '0;
            rdptr    <= '0;
            word_cnt <= '0;
            o_rddata <= '0;
        end else begin
            if (commit) begin
                wrptr <= wrptr + 1'b1;
            end
            if (racc) begin
                rdptr    <= rdptr + 1'b1;
                o_rddata <= ram_rdata;
            end
            if (commit && !racc) begin
                word_cnt <= word_cnt + 1'b1;
            end else if (racc && !commit) begin
                word_cnt <= word_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_based_fifo_return_packer.sv
// tb/tb_ram_based_fifo_return_packer.sv - randomized bench against a queue-based packing FIFO model
module tb_ram_based_fifo_return_packer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 16;
    localparam int DATA_R = 128;
    localparam int DEPTH_R = 8;
    localparam int WORDS  = 256;
    localparam int AF_TH  = 127;
    localparam int AE_TH  = 4;

    logic              system_clk;
    logic              rst_n;
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_flush;
    logic              o_full;
    logic              o_almost_full;
    logic              i_rden;
    logic [DATA_R-1:0] o_rddata;
    logic              o_empty;
    logic              o_almost_empty;
    logic [DEPTH_R:0]  o_word_cnt;
    logic [4:0]        o_pad_num;

    int checks = 0;
    int errors = 0;

    logic [DATA_R-1:0] m_q [$];
    logic [DATA_R-1:0] m_cur;
    int                m_lanes;
    int                m_pad;
    logic [DATA_R-1:0] m_rd;

    ram_based_fifo_return_packer dut (
        .system_clk     (system_clk),
        .rst_n          (rst_n),
        .i_wren         (i_wren),
        .i_wrdata       (i_wrdata),
        .i_flush        (i_flush),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .i_rden         (i_rden),
        .o_rddata       (o_rddata),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_word_cnt     (o_word_cnt),
        .o_pad_num      (o_pad_num)
    );

    initial begin
        system_clk = 1'b0;
        forever #5 system_clk = ~system_clk;
    end

    task automatic check(input string tag, input logic [DATA_R-1:0] got, input logic [DATA_R-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur   = '0;
        m_lanes = 0;
        m_pad   = 0;
        m_rd    = '0;
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        check("empty",        DATA_R'(o_empty),        DATA_R'(sz == 0));
        check("full",         DATA_R'(o_full),         DATA_R'(sz == WORDS && m_lanes == RATIO - 1));
        check("word_cnt",     DATA_R'(o_word_cnt),     DATA_R'(sz));
        check("almost_full",  DATA_R'(o_almost_full),  DATA_R'(sz >= AF_TH));
        check("almost_empty", DATA_R'(o_almost_empty), DATA_R'(sz < AE_TH));
        check("pad_num",      DATA_R'(o_pad_num),      DATA_R'(m_pad));
        check("rddata",       o_rddata,                m_rd);
    endtask

    // One clock cycle: apply inputs, advance the model over the edge, compare after it.
    task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic fl, input logic rd);
        int sz;
        bit full;
        bit wacc;
        bit racc;
        i_wren   = wr;
        i_wrdata = d;
        i_flush  = fl;
        i_rden   = rd;
        sz   = m_q.size();
        full = (sz == WORDS) && (m_lanes == RATIO - 1);
        wacc = wr && !full;
        racc = rd && (sz != 0);
        if (racc) m_rd = m_q.pop_front();
        if (wacc) begin
            m_cur[m_lanes*DATA_W +: DATA_W] = d;
            m_lanes++;
        end
        if (m_lanes == RATIO) begin
            m_q.push_back(m_cur);
            m_cur   = '0;
            m_lanes = 0;
            if (fl) m_pad = 0;
        end else if (fl && m_lanes > 0 && sz != WORDS) begin
            m_q.push_back(m_cur);
            m_pad   = RATIO - m_lanes;
            m_cur   = '0;
            m_lanes = 0;
        end
        @(posedge system_clk);
        #1;
        check_all();
    endtask

    initial begin
        int wr_pct [4];
        int rd_pct [4];
        int len    [4];
        wr_pct = '{90, 90, 90, 20};
        rd_pct = '{0, 70, 5, 90};
        len    = '{3000, 3000, 2500, 2500};

        rst_n = 1'b0;
        i_wren = 1'b0; i_wrdata = '0; i_flush = 1'b0; i_rden = 1'b0;
        model_reset();
        #12;
        check_all();
        check("reset_empty", DATA_R'(o_empty), DATA_R'(1));
        rst_n = 1'b1;

        // Sixteen ascending bytes form one word, lane 0 first.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("t1_not_empty", DATA_R'(o_empty), DATA_R'(0));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_rddata", o_rddata, 128'h0F0E0D0C0B0A09080706050403020100);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_cnt_zero", DATA_R'(o_word_cnt), DATA_R'(0));

        // Partial word flush pads upper lanes; an empty flush is a no-op.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_pad", DATA_R'(o_pad_num), DATA_R'(11));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_noop_cnt", DATA_R'(o_word_cnt), DATA_R'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_rddata", o_rddata, 128'h000000000000000000000000A5A4A3A2A1);

        // Flush coinciding with the completing byte commits exactly one word.
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("t3_cnt", DATA_R'(o_word_cnt), DATA_R'(1));
        check("t3_pad", DATA_R'(o_pad_num), DATA_R'(0));
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill RAM plus 15 lanes, hold the 16th byte, free one slot by reading.
        for (int i = 0; i < WORDS * RATIO + 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("t4_full", DATA_R'(o_full), DATA_R'(1));
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("t4_blocked_cnt", DATA_R'(o_word_cnt), DATA_R'(WORDS));
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        check("t4_full_drop", DATA_R'(o_full), DATA_R'(0));
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("t4_cnt_refill", DATA_R'(o_word_cnt), DATA_R'(WORDS));
        for (int i = 0; i < 2 * WORDS && m_q.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic in phases that push the count across both thresholds and wrap pointers.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < len[p]; c++) begin
                step(1'($urandom_range(99) < wr_pct[p]), 8'($urandom),
                     1'($urandom_range(99) < 1), 1'($urandom_range(99) < rd_pct[p]));
            end
        end
        for (int i = 0; i < 2 * WORDS && m_q.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_drained", DATA_R'(o_empty), DATA_R'(1));

        // Asynchronous reset with stored words and pending lanes.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3 * RATIO + 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        i_wren = 1'b0; i_rden = 1'b0; i_flush = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        check("t6_rddata_zero", o_rddata, '0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_clean_word", o_rddata, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
